mult_pipe_param: RTL and testbench
==================================

# mult_pipe_param

Parametrised, fully pipelined shift-add multiplier with per-sample signed/unsigned mode, valid/ready flow control, sideband tag, and a final round-and-saturate stage that produces fixed-point (Q-format) results. It sits in the FFT datapath between the twiddle ROM and the butterfly adders. It also serves any other audio-processing stage that needs one product per clock at arbitrary operand widths.

## Interface
Parameters:
- WA, 8: width of operand a
- WB, 8: width of operand b; also the number of partial-product stages
- FRAC, 0: LSBs dropped from the full product; rounding is applied, 0 ≤ FRAC < WA+WB
- OUT_W, 16: result width, 1 ≤ OUT_W ≤ WA+WB−FRAC
- TAG_W, 4: sideband tag width, ≥ 1

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous and active-high
- in_valid  in  1  operands valid
- in_ready  out  1  pipeline can accept data
- in_signed  in  1  1 = treat a and b as two's complement
- in_a  in  WA  multiplicand
- in_b  in  WB  multiplier
- in_tag  in  TAG_W  carried unchanged to the output
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_result  out  OUT_W  rounded and saturated product
- out_tag  out  TAG_W  tag of this result
- out_sat  out  1  saturation occurred on this result

## Operation
- Full product width PW = WA+WB. Arithmetic is modulo 2^PW and exact before rounding.
- Operand a is zero- or sign-extended to PW according to in_signed.
- Stage k, for k = 0..WB−1, handles bit b[k]:
  - acc += (a_ext << k) when b[k] = 1.
  - Exception: in the last stage (k = WB−1) with signed mode, the term is subtracted instead of added.
- Each stage registers acc, the shifted a, the remaining b bits, the signed flag, the tag and a valid bit.
- Output stage (stage WB):
  - If FRAC > 0: r = acc + 2^(FRAC−1), then shift right by FRAC. The shift is arithmetic in signed mode and logical in unsigned mode (round half up).
  - Saturate r to OUT_W:
    - signed range: [−2^(OUT_W−1), 2^(OUT_W−1)−1]
    - unsigned range: [0, 2^OUT_W−1]
  - out_sat = 1 when clipping occurred.
  - Rounding overflow (for example, the unsigned maximum plus half an LSB) is detected by evaluating r at PW+1 bits.
- Flow control:
  - Global stall: stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - While stalled, every pipeline register holds its value.
  - An input is accepted when in_valid & in_ready.
- Bubbles (valid = 0) propagate normally. The datapath registers of bubble slots are don't-care.

## Timing
- Latency is WB+1 cycles from acceptance to out_valid, provided no stall occurs.
- Each stall cycle adds exactly one cycle of latency to every in-flight sample.
- Throughput is one result per cycle when out_ready is held at 1.
- Reset values: all valid bits = 0, out_valid = 0, out_result = 0, out_tag = 0, out_sat = 0. in_ready = 1 as a consequence.
- Reset mid-operation: all in-flight samples are discarded. The first valid output after release comes WB+1 cycles after the first accepted input.
- out_result, out_tag and out_sat are stable while out_valid & ~out_ready (AXI-style hold).
- Simultaneous accept and emit in the same cycle is permitted; no bubble is inserted.
- in_ready depends combinationally on out_ready. This is the only combinational input-to-output path.

## Structure
- Package mult_pkg holds:
  - function prod_w(WA, WB)
  - the stage-record typedef layout (acc, a_sh, b_rem, sgn, tag, vld)
  - saturation-limit helper functions
- Sub-module mult_pipe_stage: one partial-product stage, parametrised by stage index and with an is_last flag for the signed subtract. It is instantiated WB times in a generate loop.
- Round/saturate and flow control stay in the top module.

## Test plan
- Unsigned 8×8, FRAC=0, OUT_W=16: a=255, b=255 → out_result=65025 (0xFE01) exactly 9 cycles after accept; out_sat=0.
- Signed 8×8, FRAC=0, OUT_W=16:
  - a=0x80, b=0x80 → 16384
  - a=0xFF, b=0x01 → 0xFFFF
  - a=0x7F, b=0x80 → −16256 (0xC080)
- Signed, FRAC=7, OUT_W=8:
  - a=0x40, b=0x40 → 32
  - a=0x80, b=0x80 → 127 with out_sat=1
  - a=0x01, b=0x40 → 1 (half-LSB rounds up)
- Back-to-back stream of 100 random signed and unsigned mixed samples with tags 0..15, out_ready=1 → results match the reference model in order at one per cycle, and tags are preserved.
- Stall: hold out_ready=0 for 5 cycles while a result is valid → in_ready=0 and outputs stable throughout; no loss or duplication after release.
- Assert rst for 1 cycle while 4 samples are in flight → out_valid stays 0 until WB+1 cycles after the next accepted input.

Source files
------------

// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the pipelined shift-add multiplier:
//   - prod_w()          full product width for a WA x WB multiply
//   - stage record      flat packed layout handed from stage to stage
//   - sat_hi()/sat_lo() saturation limits for a given result width and mode
// -----------------------------------------------------------------------------
package mult_pkg;

    // Widest intermediate the saturation helpers can compare against.
    localparam int MAX_W = 64;

    // Stage record, packed LSB first:
    //   vld | sgn | tag[TAG_W] | b_rem[WB] | a_sh[PW] | acc[PW]
    localparam int OFF_VLD = 0;
    localparam int OFF_SGN = 1;
    localparam int OFF_TAG = 2;

    function automatic int prod_w(input int wa, input int wb);
        return wa + wb;
    endfunction

    function automatic int off_brem(input int tag_w);
        return OFF_TAG + tag_w;
    endfunction

    function automatic int off_ash(input int wb, input int tag_w);
        return off_brem(tag_w) + wb;
    endfunction

    function automatic int off_acc(input int wa, input int wb, input int tag_w);
        return off_ash(wb, tag_w) + prod_w(wa, wb);
    endfunction

    function automatic int rec_w(input int wa, input int wb, input int tag_w);
        return off_acc(wa, wb, tag_w) + prod_w(wa, wb);
    endfunction

    // Largest representable result: 2^(w-1)-1 signed, 2^w-1 unsigned.
    function automatic logic signed [MAX_W:0] sat_hi(input int out_w, input logic sgn);
        logic signed [MAX_W:0] one;
        one = (MAX_W+1)'(1);
        return sgn ? (one <<< (out_w - 1)) - one : (one <<< out_w) - one;
    endfunction

    // Smallest representable result: -2^(w-1) signed, 0 unsigned.
    function automatic logic signed [MAX_W:0] sat_lo(input int out_w, input logic sgn);
        logic signed [MAX_W:0] one;
        one = (MAX_W+1)'(1);
        return sgn ? -(one <<< (out_w - 1)) : '0;
    endfunction

endpackage

// File: rtl/mult_pipe_stage.sv
// -----------------------------------------------------------------------------
// mult_pipe_stage
// One partial-product stage. Stage K looks at bit K of the multiplier and adds
// the already-shifted multiplicand (a_ext << K) into the accumulator; the last
// stage subtracts instead when the sample is signed (two's-complement weight of
// the multiplier MSB is negative).
// Ports:
//   clk, rst   clock, asynchronous active-high reset (valid bit only)
//   en         advance enable (low while the pipeline is stalled)
//   prev_rec   stage record from the previous stage / input
//   next_rec   registered stage record for the next stage
// -----------------------------------------------------------------------------
module mult_pipe_stage
    import mult_pkg::*;
#(
    parameter int WA      = 8,
    parameter int WB      = 8,
    parameter int TAG_W   = 4,
    parameter int K       = 0,
    parameter bit IS_LAST = 1'b0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic [rec_w(WA, WB, TAG_W)-1:0] prev_rec,
    output logic [rec_w(WA, WB, TAG_W)-1:0] next_rec
);

    localparam int PW     = prod_w(WA, WB);
    localparam int RW     = rec_w(WA, WB, TAG_W);
    localparam int O_BREM = off_brem(TAG_W);
    localparam int O_ASH  = off_ash(WB, TAG_W);
    localparam int O_ACC  = off_acc(WA, WB, TAG_W);

    logic             vld_in, sgn_in;
    logic [TAG_W-1:0] tag_in;
    logic [WB-1:0]    b_in;
    logic [PW-1:0]    a_sh_in, acc_in, term, acc_nxt;

    assign vld_in  = prev_rec[OFF_VLD];
    assign sgn_in  = prev_rec[OFF_SGN];
    assign tag_in  = prev_rec[O_BREM-1:OFF_TAG];
    assign b_in    = prev_rec[O_ASH-1:O_BREM];
    assign a_sh_in = prev_rec[O_ACC-1:O_ASH];
    assign acc_in  = prev_rec[RW-1:O_ACC];

    assign term    = b_in[K] ? a_sh_in : '0;
    assign acc_nxt = (IS_LAST && sgn_in) ? acc_in - term : acc_in + term;

    logic             vld_pk, sgn_pk;
    logic [TAG_W-1:0] tag_pk;
    logic [WB-1:0]    b_pk;
    logic [PW-1:0]    a_sh_pk, acc_pk;

    // ---- stage K register boundary ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     vld_pk <= 1'b0;
        else if (en) vld_pk <= vld_in;
    end

    // Datapath of bubble slots is don't-care, so no reset here.
    always_ff @(posedge clk) begin
        if (en) begin
            acc_pk  <= acc_nxt;
            a_sh_pk <= a_sh_in << 1;
            b_pk    <= b_in;
            sgn_pk  <= sgn_in;
            tag_pk  <= tag_in;
        end
    end

    assign next_rec = {acc_pk, a_sh_pk, b_pk, tag_pk, sgn_pk, vld_pk};

endmodule

// File: rtl/mult_pipe_param.sv
// -----------------------------------------------------------------------------
// mult_pipe_param
// Fully pipelined WA x WB shift-add multiplier, one product per clock, with
// per-sample signed/unsigned mode, a sideband tag, and a final round (half up)
// and saturate stage producing an OUT_W-bit Q-format result (FRAC LSBs dropped).
// Latency is WB+1 cycles; a stall freezes every stage.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   in_valid/in_ready           input handshake (in_ready = ~stall, combinational)
//   in_signed, in_a, in_b       mode and operands
//   in_tag                      sideband carried to out_tag
//   out_valid/out_ready         output handshake, outputs held while stalled
//   out_result, out_tag,out_sat rounded/saturated product, tag, clip flag
// -----------------------------------------------------------------------------
module mult_pipe_param
    import mult_pkg::*;
#(
    parameter int WA    = 8,
    parameter int WB    = 8,
    parameter int FRAC  = 0,
    parameter int OUT_W = 16,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WA-1:0]    in_a,
    input  logic [WB-1:0]    in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_sat
);

    localparam int PW      = prod_w(WA, WB);
    localparam int RW      = rec_w(WA, WB, TAG_W);
    localparam int O_BREM  = off_brem(TAG_W);
    localparam int O_ACC   = off_acc(WA, WB, TAG_W);
    localparam int HALF_SH = (FRAC > 0) ? FRAC - 1 : 0;
    localparam logic [PW:0] HALF = (FRAC > 0) ? ((PW+1)'(1) << HALF_SH) : '0;

    // Round half up at PW+1 bits so a carry out of the top bit is kept.
    function automatic logic [PW:0] round_q(input logic [PW-1:0] acc, input logic sgn);
        logic [PW:0] x;
        x = {sgn & acc[PW-1], acc} + HALF;
        if (sgn) return $unsigned($signed(x) >>> FRAC);
        return x >> FRAC;
    endfunction

    // Returns {clipped, result}.
    function automatic logic [OUT_W:0] sat_q(input logic [PW:0] r, input logic sgn);
        logic signed [MAX_W:0] v, hi, lo;
        if (sgn) v = (MAX_W+1)'($signed(r));
        else     v = (MAX_W+1)'(r);
        hi = sat_hi(OUT_W, sgn);
        lo = sat_lo(OUT_W, sgn);
        if (v > hi) return {1'b1, hi[OUT_W-1:0]};
        if (v < lo) return {1'b1, lo[OUT_W-1:0]};
        return {1'b0, v[OUT_W-1:0]};
    endfunction

    logic          stall, en;
    logic [PW-1:0] a_ext;
    logic [RW-1:0] rec [WB+1];

    assign stall    = out_valid & ~out_ready;
    assign en       = ~stall;
    assign in_ready = ~stall;

    assign a_ext  = in_signed ? PW'($signed(in_a)) : PW'(in_a);
    assign rec[0] = {{PW{1'b0}}, a_ext, in_b, in_tag, in_signed, in_valid & in_ready};

    for (genvar k = 0; k < WB; k++) begin : g_stage
        mult_pipe_stage #(
            .WA      (WA),
            .WB      (WB),
            .TAG_W   (TAG_W),
            .K       (k),
            .IS_LAST (k == WB - 1)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .prev_rec (rec[k]),
            .next_rec (rec[k+1])
        );
    end

    logic [PW-1:0]          acc_last;
    logic [TAG_W-1:0]       tag_last;
    logic                   sgn_last, vld_last;
    logic [O_ACC-O_BREM-1:0] unused_last;

    assign vld_last    = rec[WB][OFF_VLD];
    assign sgn_last    = rec[WB][OFF_SGN];
    assign tag_last    = rec[WB][O_BREM-1:OFF_TAG];
    assign acc_last    = rec[WB][RW-1:O_ACC];
    // Shifted multiplicand and multiplier bits are spent after the last stage.
    assign unused_last = rec[WB][O_ACC-1:O_BREM];

    logic [PW:0]    rnd;
    logic [OUT_W:0] sat_res;

    assign rnd     = round_q(acc_last, sgn_last);
    assign sat_res = sat_q(rnd, sgn_last);

    // ---- output stage (WB) register boundary ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            out_sat    <= 1'b0;
        end else if (en) begin
            out_valid <= vld_last;
            if (vld_last) begin
                out_result <= sat_res[OUT_W-1:0];
                out_sat    <= sat_res[OUT_W];
                out_tag    <= tag_last;
            end
        end
    end

endmodule

// File: tb/tb_mult_pipe_param.sv
// Bench: two instances share stimulus -- dut0 (FRAC=0, OUT_W=16) and
// dut1 (FRAC=7, OUT_W=8) -- with a scoreboard queue per instance.
module tb_mult_pipe_param;

    typedef struct packed {
        logic [15:0] res;
        logic        sat;
        logic [3:0]  tag;
    } exp_t;

    logic        clk, rst, in_valid, in_signed, out_ready;
    logic [7:0]  in_a, in_b;
    logic [3:0]  in_tag;
    logic        in_ready0, out_valid0, out_sat0;
    logic        in_ready1, out_valid1, out_sat1;
    logic [15:0] out_result0;
    logic [7:0]  out_result1;
    logic [3:0]  out_tag0, out_tag1;

    int   n_checks = 0, n_pass = 0, n_fail = 0;
    int   run_len = 0, max_run = 0;
    exp_t q0[$], q1[$];
    exp_t e0, e1;

    mult_pipe_param #(.WA(8), .WB(8), .FRAC(0), .OUT_W(16), .TAG_W(4)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_signed(in_signed), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid0), .out_ready(out_ready), .out_result(out_result0),
        .out_tag(out_tag0), .out_sat(out_sat0));

    mult_pipe_param #(.WA(8), .WB(8), .FRAC(7), .OUT_W(8), .TAG_W(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_signed(in_signed), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid1), .out_ready(out_ready), .out_result(out_result1),
        .out_tag(out_tag1), .out_sat(out_sat1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: exact integer product, round half up, clip to ow bits.
    function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                                  input int frac, input int ow,
                                  output logic [15:0] res, output logic sat);
        longint p, r, hi, lo;
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        if (sgn) p = longint'(sa) * longint'(sb);
        else     p = longint'(a) * longint'(b);
        r = p;
        if (frac > 0) r = (p + (longint'(1) << (frac - 1))) >>> frac;
        hi = sgn ? (longint'(1) << (ow - 1)) - 1 : (longint'(1) << ow) - 1;
        lo = sgn ? -(longint'(1) << (ow - 1)) : 0;
        sat = 1'b0;
        if (r > hi) begin r = hi; sat = 1'b1; end
        if (r < lo) begin r = lo; sat = 1'b1; end
        res = 16'(r);
        if (ow < 16) res = res & ((16'd1 << ow) - 16'd1);
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                         input logic [3:0] tag, input logic [15:0] x0, input logic s0,
                         input logic [7:0] x1, input logic s1);
        int w = 0;
        exp_t x;
        in_valid = 1'b1; in_a = a; in_b = b; in_signed = sgn; in_tag = tag;
        @(negedge clk);
        while (!in_ready0 && w < 50) begin @(negedge clk); w++; end
        check("accept_wait", 32'(in_ready0), 1);
        @(posedge clk);
        x.res = x0;        x.sat = s0; x.tag = tag; q0.push_back(x);
        x.res = 16'(x1);   x.sat = s1; x.tag = tag; q1.push_back(x);
        #1;
    endtask

    task automatic drive_model(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                               input logic [3:0] tag);
        logic [15:0] r0, r1;
        logic        s0, s1;
        model(a, b, sgn, 0, 16, r0, s0);
        model(a, b, sgn, 7, 8, r1, s1);
        drive(a, b, sgn, tag, r0, s0, r1[7:0], s1);
    endtask

    task automatic drain();
        int w = 0;
        while ((q0.size() != 0 || q1.size() != 0) && w < 80) begin @(negedge clk); w++; end
        check("drain_empty", 32'(q0.size() + q1.size()), 0);
        @(posedge clk); #1;
    endtask

    // Counts rising edges from the accepting edge until out_valid is seen.
    task automatic latency(output int lat);
        lat = 1;
        while (lat < 40) begin
            @(negedge clk);
            if (out_valid0) break;
            @(posedge clk);
            lat++;
        end
    endtask

    // Scoreboard: compare each transferred result against the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid0 && out_ready) begin
                check("sb0_nonempty", 32'(q0.size() != 0), 1);
                if (q0.size() != 0) begin
                    e0 = q0.pop_front();
                    check("dut0_result", 32'(out_result0), 32'(e0.res));
                    check("dut0_sat", 32'(out_sat0), 32'(e0.sat));
                    check("dut0_tag", 32'(out_tag0), 32'(e0.tag));
                end
            end
            if (out_valid1 && out_ready) begin
                check("sb1_nonempty", 32'(q1.size() != 0), 1);
                if (q1.size() != 0) begin
                    e1 = q1.pop_front();
                    check("dut1_result", 32'(out_result1), 32'(e1.res));
                    check("dut1_sat", 32'(out_sat1), 32'(e1.sat));
                    check("dut1_tag", 32'(out_tag1), 32'(e1.tag));
                end
            end
            if (out_valid0 && out_ready) run_len++;
            else run_len = 0;
            if (run_len > max_run) max_run = run_len;
        end
    end

    initial begin
        int          lat;
        logic [31:0] snap0, snap1;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0;
        in_tag = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'({out_valid0, out_valid1}), 0);
        check("rst_out_result0", 32'(out_result0), 0);
        check("rst_out_result1", 32'(out_result1), 0);
        check("rst_out_tag_sat", 32'({out_tag0, out_sat0, out_tag1, out_sat1}), 0);
        check("rst_in_ready", 32'({in_ready0, in_ready1}), 32'h3);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        // Unsigned 255 x 255 and its latency
        drive(8'hFF, 8'hFF, 1'b0, 4'h1, 16'hFE01, 1'b0, 8'hFF, 1'b1);
        in_valid = 1'b0;
        latency(lat);
        check("latency_first", 32'(lat), 9);
        check("umax_result", 32'(out_result0), 32'hFE01);
        check("umax_sat", 32'(out_sat0), 0);
        drain();

        // Directed signed/unsigned corner cases, back to back
        drive(8'h80, 8'h80, 1'b1, 4'h2, 16'h4000, 1'b0, 8'h7F, 1'b1);
        drive(8'hFF, 8'h01, 1'b1, 4'h3, 16'hFFFF, 1'b0, 8'h00, 1'b0);
        drive(8'h7F, 8'h80, 1'b1, 4'h4, 16'hC080, 1'b0, 8'h81, 1'b0);
        drive(8'h40, 8'h40, 1'b1, 4'h5, 16'h1000, 1'b0, 8'h20, 1'b0);
        drive(8'h01, 8'h40, 1'b1, 4'h6, 16'h0040, 1'b0, 8'h01, 1'b0);
        drive(8'hFF, 8'h40, 1'b1, 4'h7, 16'hFFC0, 1'b0, 8'h00, 1'b0);
        drive(8'h01, 8'h40, 1'b0, 4'h8, 16'h0040, 1'b0, 8'h01, 1'b0);
        drive(8'h3F, 8'h01, 1'b0, 4'h9, 16'h003F, 1'b0, 8'h00, 1'b0);
        in_valid = 1'b0;
        drain();

        // Random mixed-mode stream at full rate
        max_run = 0;
        for (int i = 0; i < 100; i++)
            drive_model(8'($urandom), 8'($urandom), 1'($urandom), 4'(i % 16));
        in_valid = 1'b0;
        drain();
        check("stream_full_rate", 32'(max_run >= 100), 1);

        // Stall: back-pressure while a result is waiting
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++)
            drive_model(8'($urandom), 8'($urandom), 1'($urandom), 4'(i + 1));
        in_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!out_valid0 && lat < 20) begin @(negedge clk); lat++; end
        check("stall_arrive", 32'({out_valid0, out_valid1}), 32'h3);
        snap0 = 32'({out_valid0, out_sat0, out_tag0, out_result0});
        snap1 = 32'({out_valid1, out_sat1, out_tag1, out_result1});
        repeat (5) begin
            @(negedge clk);
            check("stall_in_ready", 32'({in_ready0, in_ready1}), 0);
            check("stall_hold0", 32'({out_valid0, out_sat0, out_tag0, out_result0}), snap0);
            check("stall_hold1", 32'({out_valid1, out_sat1, out_tag1, out_result1}), snap1);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        drain();

        // Reset with four samples in flight
        for (int i = 0; i < 4; i++)
            drive_model(8'($urandom), 8'($urandom), 1'($urandom), 4'(i + 10));
        in_valid = 1'b0;
        rst = 1'b1;
        q0.delete();
        q1.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_outputs0", 32'({out_valid0, out_sat0, out_tag0, out_result0}), 0);
        check("midrst_in_ready", 32'({in_ready0, in_ready1}), 32'h3);
        repeat (12) begin
            @(negedge clk);
            check("midrst_flushed", 32'({out_valid0, out_valid1}), 0);
        end
        @(posedge clk); #1;
        drive(8'h10, 8'h20, 1'b0, 4'hE, 16'h0200, 1'b0, 8'h04, 1'b0);
        in_valid = 1'b0;
        latency(lat);
        check("latency_after_rst", 32'(lat), 9);
        drain();
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
